reg_file_sb: RTL and testbench
==============================

# reg_file_sb

Parametrised successor to the core's integer register file: `NREG` × `XLEN` storage with two combinational read ports and one synchronous write port. Adds same-cycle write-to-read bypass and a per-register busy scoreboard, so a pipelined core can detect RAW hazards on in-flight destinations. It sits between decode (reads and reservations) and writeback (writes and busy release).

## Interface
- `XLEN`, 32, data width in bits.
- `NREG`, 32, register count, power of two, ≥ 2; register 0 is hardwired zero.
- `AW`, $clog2(NREG), address width; derived, never overridden.
- `BYPASS`, 1, 1 = same-cycle write data forwarded to reads; 0 = reads return stored value only.

Ports:
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `rs1_addr`  in  AW  read port 1 address.
- `rs2_addr`  in  AW  read port 2 address.
- `rs1_out`  out  XLEN  read port 1 data.
- `rs2_out`  out  XLEN  read port 2 data.
- `rs1_busy`  out  1  read port 1 register has a pending producer.
- `rs2_busy`  out  1  read port 2 register has a pending producer.
- `wr_en`  in  1  writeback strobe.
- `rd_addr`  in  AW  writeback address.
- `data_in`  in  XLEN  writeback data.
- `rsv_en`  in  1  reserve strobe: mark `rsv_addr` busy.
- `rsv_addr`  in  AW  reservation address.
- `pend_cnt`  out  AW+1  number of busy registers.

## Operation
- Reset (`rst_n` low, any time, including mid-operation): all registers 0, all busy bits 0, `pend_cnt` 0. All outputs are 0 while reset is held, whatever the read addresses.
- Write: on a rising edge with `wr_en`=1 and `rd_addr`≠0, `regfile[rd_addr]` ← `data_in` and `busy[rd_addr]` ← 0. A write to address 0 is ignored.
- Reserve: on a rising edge with `rsv_en`=1 and `rsv_addr`≠0, `busy[rsv_addr]` ← 1. A reservation of address 0 is ignored.
- Reserve and write to the same address in the same cycle: the data is written and the register **stays busy**, because the reservation is a newer producer.
- Reserve to an already-busy register: no change. Write to a non-busy register: data is written and `pend_cnt` is unchanged.
- `pend_cnt` is a registered counter that changes by +1, −1 or 0 per cycle, depending on the net set/clear of busy bits. It always equals the popcount of `busy`. It never exceeds NREG−1.
- Read, for each port n:
  - If `rsn_addr`=0: `rsn_out`=0 and `rsn_busy`=0.
  - Else, if `BYPASS`=1, `wr_en`=1 and `rd_addr`=`rsn_addr`: `rsn_out`=`data_in`, and `rsn_busy`=0 unless `rsv_en`=1 with `rsv_addr`=`rsn_addr` in the same cycle (then 1).
  - Otherwise: `rsn_out`=`regfile[rsn_addr]` and `rsn_busy`=`busy[rsn_addr]`.
  - Same-cycle reservations do not affect `rsn_busy` in any other case; they are visible from the next cycle.
- Both ports read the same address independently and identically.

## Timing
- Reads are combinational: zero-cycle latency from address to data and busy.
- Writes and reservations take effect at the rising edge. With `BYPASS`=0, written data is visible the cycle after `wr_en`.
- `pend_cnt` updates at the same edge as the busy bits. It has no combinational path from inputs.
- Bypass paths run from `data_in`/`wr_en`/`rd_addr` to `rsn_out`/`rsn_busy`. Upstream logic must not close a combinational loop through them.

## Structure
- Shared package `reg_file_pkg`: default `XLEN`/`NREG` localparams, the `reg_addr_t` typedef (logic [AW-1:0]) and the `ZERO_REG` constant.
- One sub-module, `reg_scoreboard`, holds the busy bit vector, the set/clear priority and `pend_cnt`. The top level holds the storage array, the x0 masking and the bypass muxes.

## Test plan
- Reset: write 0xDEADBEEF to x5, assert `rst_n` low mid-cycle → `rs1_out`=0 immediately, `pend_cnt`=0, and x5 reads 0 after release.
- x0: write 0x1234 and reserve to address 0 → `rs1_out`=0, `rs1_busy`=0, `pend_cnt`=0.
- Bypass: `BYPASS`=1, `wr_en`=1, `rd_addr`=7, `data_in`=0xA5A5A5A5, `rs2_addr`=7 in the same cycle → `rs2_out`=0xA5A5A5A5. With `BYPASS`=0 the old value is returned that cycle and the new value the next.
- Scoreboard: reserve x3, x4, x3 → `pend_cnt`=2. Write x3 → `rs1_busy`(x3)=0 and `pend_cnt`=1.
- Simultaneous: x9 busy; reserve x9 and write x9=0x55 in the same cycle → `rs1_busy`=1 that cycle and after, x9 reads 0x55, `pend_cnt` unchanged.
- Full: reserve x1..x(NREG−1) → `pend_cnt`=NREG−1. Reserve and write different registers in one cycle → count unchanged.

Source files
------------

// File: rtl/reg_file_pkg.sv
// reg_file_pkg
//   Shared definitions for the register file slice: default geometry,
//   the register address type and the hardwired-zero register index.
//   No ports; imported by reg_scoreboard and reg_file_sb.
package reg_file_pkg;

  localparam int XLEN_DEFAULT = 32;
  localparam int NREG_DEFAULT = 32;
  localparam int AW_DEFAULT   = $clog2(NREG_DEFAULT);

  typedef logic [AW_DEFAULT-1:0] reg_addr_t;

  // x0 always reads as zero and is never written or reserved.
  localparam reg_addr_t ZERO_REG = '0;

endpackage : reg_file_pkg

// File: rtl/reg_scoreboard.sv
// reg_scoreboard
//   Per-register busy bits plus a registered count of busy registers.
//   A reservation marks a register busy (a new producer is in flight);
//   a writeback clears it. When both hit the same register in one cycle
//   the reservation wins, since it is the newer producer.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   wr_en, rd_addr      writeback strobe / address (clears busy)
//   rsv_en, rsv_addr    reserve strobe / address (sets busy)
//   busy                current busy vector, bit 0 always 0
//   pend_cnt            popcount of busy, registered
module reg_scoreboard
  import reg_file_pkg::*;
#(
  parameter int NREG = NREG_DEFAULT
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      wr_en,
  input  logic [$clog2(NREG)-1:0]   rd_addr,
  input  logic                      rsv_en,
  input  logic [$clog2(NREG)-1:0]   rsv_addr,
  output logic [NREG-1:0]           busy,
  output logic [$clog2(NREG):0]     pend_cnt
);

  localparam int AW = $clog2(NREG);
  localparam logic [AW-1:0] X0 = AW'(ZERO_REG);

  logic            set_hit;
  logic            clr_hit;
  logic [NREG-1:0] set_vec;
  logic [NREG-1:0] clr_vec;
  logic [NREG-1:0] busy_nxt;
  logic            cnt_inc;
  logic            cnt_dec;

  // Set wins over clear. The count moves only on real transitions: a
  // reservation of an idle register adds one, a writeback of a busy
  // register that is not re-reserved in the same cycle removes one.
  always_comb begin
    set_hit  = rsv_en && (rsv_addr != X0);
    clr_hit  = wr_en  && (rd_addr  != X0);
    set_vec  = '0;
    clr_vec  = '0;
    if (set_hit) set_vec[rsv_addr] = 1'b1;
    if (clr_hit) clr_vec[rd_addr]  = 1'b1;
    busy_nxt = (busy & ~clr_vec) | set_vec;
    cnt_inc  = set_hit && !busy[rsv_addr];
    cnt_dec  = clr_hit && busy[rd_addr] && !(set_hit && (rsv_addr == rd_addr));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy     <= '0;
      pend_cnt <= '0;
    end else begin
      busy <= busy_nxt;
      if (cnt_inc && !cnt_dec) begin
        pend_cnt <= pend_cnt + 1'b1;
      end else if (cnt_dec && !cnt_inc) begin
        pend_cnt <= pend_cnt - 1'b1;
      end
    end
  end

endmodule : reg_scoreboard

// File: rtl/reg_file_sb.sv
// reg_file_sb
//   NREG x XLEN integer register file with two combinational read ports,
//   one synchronous write port, optional same-cycle write-to-read bypass
//   and a busy scoreboard for RAW hazard detection on in-flight results.
// Ports:
//   clk, rst_n                    clock, asynchronous active-low reset
//   rs1_addr/rs2_addr             read addresses
//   rs1_out/rs2_out               read data (0 for x0 and during reset)
//   rs1_busy/rs2_busy             register has a pending producer
//   wr_en, rd_addr, data_in       writeback port
//   rsv_en, rsv_addr              destination reservation from decode
//   pend_cnt                      number of busy registers
module reg_file_sb
  import reg_file_pkg::*;
#(
  parameter int XLEN   = XLEN_DEFAULT,
  parameter int NREG   = NREG_DEFAULT,
  parameter bit BYPASS = 1'b1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [$clog2(NREG)-1:0]   rs1_addr,
  input  logic [$clog2(NREG)-1:0]   rs2_addr,
  output logic [XLEN-1:0]           rs1_out,
  output logic [XLEN-1:0]           rs2_out,
  output logic                      rs1_busy,
  output logic                      rs2_busy,
  input  logic                      wr_en,
  input  logic [$clog2(NREG)-1:0]   rd_addr,
  input  logic [XLEN-1:0]           data_in,
  input  logic                      rsv_en,
  input  logic [$clog2(NREG)-1:0]   rsv_addr,
  output logic [$clog2(NREG):0]     pend_cnt
);

  localparam int AW = $clog2(NREG);
  localparam logic [AW-1:0] X0 = AW'(ZERO_REG);

  logic [XLEN-1:0] regs [NREG];
  logic [NREG-1:0] busy;
  logic [AW-1:0]   port_addr [2];
  logic [XLEN-1:0] port_data [2];
  logic            port_busy [2];

  reg_scoreboard #(
    .NREG (NREG)
  ) u_scoreboard (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (wr_en),
    .rd_addr  (rd_addr),
    .rsv_en   (rsv_en),
    .rsv_addr (rsv_addr),
    .busy     (busy),
    .pend_cnt (pend_cnt)
  );

  // Storage array; entry 0 is never written so it stays zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_en && (rd_addr != X0)) begin
      regs[rd_addr] <= data_in;
    end
  end

  assign port_addr[0] = rs1_addr;
  assign port_addr[1] = rs2_addr;

  // Read mux per port. On a bypass hit the stored busy bit is stale (the
  // writeback is clearing it), so busy only reflects a reservation of the
  // same register arriving in the same cycle.
  for (genvar p = 0; p < 2; p++) begin : g_read
    always_comb begin
      port_data[p] = regs[port_addr[p]];
      port_busy[p] = busy[port_addr[p]];
      if (port_addr[p] == X0) begin
        port_data[p] = '0;
        port_busy[p] = 1'b0;
      end else if (BYPASS && wr_en && (rd_addr == port_addr[p])) begin
        port_data[p] = data_in;
        port_busy[p] = rsv_en && (rsv_addr == port_addr[p]);
      end
    end
  end

  // Reads are forced to zero while reset is held so the bypass path
  // cannot leak writeback data out of a core that is in reset.
  assign rs1_out  = rst_n ? port_data[0] : '0;
  assign rs2_out  = rst_n ? port_data[1] : '0;
  assign rs1_busy = rst_n && port_busy[0];
  assign rs2_busy = rst_n && port_busy[1];

endmodule : reg_file_sb

// File: tb/tb_reg_file_sb.sv
// tb_reg_file_sb
//   Directed bench for reg_file_sb. Two instances share all inputs: one
//   with bypass enabled, one without, so the bypass/no-bypass contrast is
//   observed on the same stimulus.
module tb_reg_file_sb;

  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int AW   = $clog2(NREG);

  logic            clk;
  logic            rst_n;
  logic [AW-1:0]   rs1_addr;
  logic [AW-1:0]   rs2_addr;
  logic            wr_en;
  logic [AW-1:0]   rd_addr;
  logic [XLEN-1:0] data_in;
  logic            rsv_en;
  logic [AW-1:0]   rsv_addr;

  logic [XLEN-1:0] rs1_out,    rs2_out;
  logic            rs1_busy,   rs2_busy;
  logic [AW:0]     pend_cnt;
  logic [XLEN-1:0] nb_rs1_out, nb_rs2_out;
  logic            nb_rs1_busy, nb_rs2_busy;
  logic [AW:0]     nb_pend_cnt;

  int vec_cnt;
  int err_cnt;

  reg_file_sb #(.XLEN(XLEN), .NREG(NREG), .BYPASS(1'b1)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rs1_addr (rs1_addr),
    .rs2_addr (rs2_addr),
    .rs1_out  (rs1_out),
    .rs2_out  (rs2_out),
    .rs1_busy (rs1_busy),
    .rs2_busy (rs2_busy),
    .wr_en    (wr_en),
    .rd_addr  (rd_addr),
    .data_in  (data_in),
    .rsv_en   (rsv_en),
    .rsv_addr (rsv_addr),
    .pend_cnt (pend_cnt)
  );

  reg_file_sb #(.XLEN(XLEN), .NREG(NREG), .BYPASS(1'b0)) dut_nb (
    .clk      (clk),
    .rst_n    (rst_n),
    .rs1_addr (rs1_addr),
    .rs2_addr (rs2_addr),
    .rs1_out  (nb_rs1_out),
    .rs2_out  (nb_rs2_out),
    .rs1_busy (nb_rs1_busy),
    .rs2_busy (nb_rs2_busy),
    .wr_en    (wr_en),
    .rd_addr  (rd_addr),
    .data_in  (data_in),
    .rsv_en   (rsv_en),
    .rsv_addr (rsv_addr),
    .pend_cnt (nb_pend_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value against its expected value.
  task automatic checkOutput(input string tag, input logic [XLEN-1:0] actual,
                             input logic [XLEN-1:0] expected);
    vec_cnt++;
    if (actual !== expected) begin
      err_cnt++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
    end
  endtask

  // Drive one cycle's worth of inputs, then let combinational reads settle.
  task automatic applyStimulus(input logic we, input logic [AW-1:0] rd,
                               input logic [XLEN-1:0] din, input logic rv,
                               input logic [AW-1:0] rva,
                               input logic [AW-1:0] a1, input logic [AW-1:0] a2);
    wr_en    = we;
    rd_addr  = rd;
    data_in  = din;
    rsv_en   = rv;
    rsv_addr = rva;
    rs1_addr = a1;
    rs2_addr = a2;
    #1;
  endtask

  // Commit the current inputs at the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vec_cnt = 0;
    err_cnt = 0;
    rst_n   = 1'b0;
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd5, 5'd0);
    #1;
    checkOutput("reset_rs1_out", rs1_out, 32'h0);
    checkOutput("reset_pend",    XLEN'(pend_cnt), 32'd0);
    #10;
    rst_n = 1'b1;
    tick();

    // Write x5, reserve x6, then reset mid-cycle.
    applyStimulus(1'b1, 5'd5, 32'hDEADBEEF, 1'b1, 5'd6, 5'd5, 5'd6);
    tick();
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd5, 5'd6);
    checkOutput("x5_written",  rs1_out, 32'hDEADBEEF);
    checkOutput("x6_busy",     XLEN'(rs2_busy), 32'd1);
    checkOutput("pend_one",    XLEN'(pend_cnt), 32'd1);
    applyStimulus(1'b1, 5'd5, 32'hFFFF0000, 1'b0, 5'd0, 5'd5, 5'd6);
    rst_n = 1'b0;
    #1;
    checkOutput("rst_rs1_out_now", rs1_out, 32'h0);
    checkOutput("rst_rs2_busy",    XLEN'(rs2_busy), 32'd0);
    checkOutput("rst_pend_now",    XLEN'(pend_cnt), 32'd0);
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd5, 5'd6);
    rst_n = 1'b1;
    #1;
    checkOutput("x5_after_reset", rs1_out, 32'h0);
    tick();

    // x0 is never written nor reserved.
    applyStimulus(1'b1, 5'd0, 32'h1234, 1'b1, 5'd0, 5'd0, 5'd0);
    checkOutput("x0_out_same",  rs1_out, 32'h0);
    checkOutput("x0_busy_same", XLEN'(rs1_busy), 32'd0);
    tick();
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0);
    checkOutput("x0_out_next", rs1_out, 32'h0);
    checkOutput("x0_pend",     XLEN'(pend_cnt), 32'd0);

    // Bypass vs stored read on x7.
    applyStimulus(1'b1, 5'd7, 32'h11111111, 1'b0, 5'd0, 5'd0, 5'd7);
    tick();
    applyStimulus(1'b1, 5'd7, 32'hA5A5A5A5, 1'b0, 5'd0, 5'd0, 5'd7);
    checkOutput("byp_rs2_out",   rs2_out, 32'hA5A5A5A5);
    checkOutput("byp_rs2_busy",  XLEN'(rs2_busy), 32'd0);
    checkOutput("nobyp_old_val", nb_rs2_out, 32'h11111111);
    tick();
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd7);
    checkOutput("nobyp_new_val", nb_rs2_out, 32'hA5A5A5A5);
    checkOutput("write_idle_pend", XLEN'(pend_cnt), 32'd0);

    // Scoreboard: reserve x3, x4, x3 again.
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 5'd3, 5'd4);
    checkOutput("rsv_not_visible_yet", XLEN'(rs1_busy), 32'd0);
    tick();
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd4, 5'd3, 5'd4);
    tick();
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 5'd3, 5'd4);
    tick();
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd3, 5'd4);
    checkOutput("pend_two",  XLEN'(pend_cnt), 32'd2);
    checkOutput("x3_busy",   XLEN'(rs1_busy), 32'd1);
    applyStimulus(1'b1, 5'd3, 32'h33, 1'b0, 5'd0, 5'd3, 5'd4);
    checkOutput("x3_byp_busy",    XLEN'(rs1_busy), 32'd0);
    checkOutput("x3_nobyp_busy",  XLEN'(nb_rs1_busy), 32'd1);
    tick();
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd3, 5'd4);
    checkOutput("x3_released",  XLEN'(rs1_busy), 32'd0);
    checkOutput("x4_still",     XLEN'(rs2_busy), 32'd1);
    checkOutput("pend_after_wr", XLEN'(pend_cnt), 32'd1);

    // Simultaneous reserve and write on a busy x9.
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 5'd9, 5'd0);
    tick();
    applyStimulus(1'b1, 5'd9, 32'h55, 1'b1, 5'd9, 5'd9, 5'd0);
    checkOutput("sim_busy_same",  XLEN'(rs1_busy), 32'd1);
    checkOutput("sim_out_same",   rs1_out, 32'h55);
    tick();
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd9, 5'd0);
    checkOutput("sim_busy_after", XLEN'(rs1_busy), 32'd1);
    checkOutput("sim_out_after",  rs1_out, 32'h55);
    checkOutput("sim_pend",       XLEN'(pend_cnt), 32'd2);

    // Fill the scoreboard.
    for (int i = 1; i < NREG; i++) begin
      applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, AW'(i), 5'd0, 5'd0);
      tick();
    end
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0);
    checkOutput("pend_full", XLEN'(pend_cnt), 32'(NREG - 1));
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 5'd0, 5'd0);
    tick();
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0);
    checkOutput("pend_full_rersv", XLEN'(pend_cnt), 32'(NREG - 1));
    applyStimulus(1'b1, 5'd10, 32'hA0, 1'b0, 5'd0, 5'd0, 5'd0);
    tick();
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd10, 5'd0);
    checkOutput("pend_minus_one", XLEN'(pend_cnt), 32'(NREG - 2));
    applyStimulus(1'b1, 5'd12, 32'hC0, 1'b1, 5'd10, 5'd10, 5'd12);
    checkOutput("rsv_hidden_same", XLEN'(rs1_busy), 32'd0);
    tick();
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd10, 5'd12);
    checkOutput("pend_rsv_wr_diff", XLEN'(pend_cnt), 32'(NREG - 2));
    checkOutput("x10_busy_next",    XLEN'(rs1_busy), 32'd1);
    checkOutput("x12_cleared",      XLEN'(rs2_busy), 32'd0);
    checkOutput("x12_data",         rs2_out, 32'hC0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule : tb_reg_file_sb
